mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the 2-read/1-write, 2048x32 data memory between NUM_CLIENTS requesters (client 0 = instruction fetch, 1 = load/store unit, 2 = debug/loader).
- Each cycle it grants up to two reads, one per memory read port, and one write.
- Selection is round-robin, and a read to the address being written in the same cycle is held off.
- It routes the one-cycle-latency read data and write acks back to the owning client using per-port owner tags.

Parameters:
- NUM_CLIENTS, 3, number of requesters (2..8).
- ADDR_W, 11, memory address width.
- DATA_W, 32, memory data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cl_req  input  NUM_CLIENTS  per-client request; held until granted.
- cl_we  input  NUM_CLIENTS  per-client 1 = write, 0 = read.
- cl_addr  input  NUM_CLIENTS*ADDR_W  per-client address; client i at [i*ADDR_W +: ADDR_W].
- cl_wdata  input  NUM_CLIENTS*DATA_W  per-client write data.
- cl_gnt  output  NUM_CLIENTS  per-client grant; combinational, same cycle as the request.
- cl_rvalid  output  NUM_CLIENTS  per-client read data valid.
- cl_rdata  output  NUM_CLIENTS*DATA_W  per-client read data.
- cl_wack  output  NUM_CLIENTS  per-client write complete.
- mem_r_adrs1, mem_r_adrs2  output  ADDR_W  read addresses to memory ports 1 and 2.
- mem_r_en1, mem_r_en2  output  1  read enables to memory ports 1 and 2.
- mem_w_adrs  output  ADDR_W  write address to memory.
- mem_data_in  output  DATA_W  write data to memory.
- mem_w_en  output  1  write enable to memory.
- mem_r_valid1, mem_r_valid2  input  1  memory read-valid strobes.
- mem_w_valid  input  1  memory write-valid strobe.
- mem_data_out1, mem_data_out2  input  DATA_W  memory read data.

Behaviour:
- State:
  - rd_ptr and wr_ptr, each a client index.
  - Per read port p (1, 2): own_v[p] (1 bit) and own_id[p] (client index).
  - wr_own_v and wr_own_id for the write port.
- Reset (reset=1 at clk edge):
  - Both pointers are set to 0, and all own_v and wr_own_v are set to 0.
  - While reset=1, cl_gnt=0 and all mem enables are 0.
  - cl_rvalid, cl_wack and cl_rdata are 0 during reset and in the cycle after it.
  - Reads in flight when reset is asserted are dropped: the memory strobe returning afterwards is ignored because own_v=0.
- Write arbitration (combinational):
  - Candidates are clients with req & we.
  - Scan from wr_ptr upward, modulo NUM_CLIENTS; the first candidate wins.
  - The winner drives mem_w_adrs and mem_data_in, and mem_w_en=1.
- Read arbitration (combinational):
  - Candidates are clients with req & !we whose address does not equal the granted write address in this cycle (read-after-write hold-off; no forwarding).
  - Scan from rd_ptr upward, modulo NUM_CLIENTS.
  - The first candidate gets port 1 (mem_r_en1=1) and the second gets port 2 (mem_r_en2=1); any others wait.
- cl_gnt[i] = 1 iff client i won a read port or the write port. The client may change req, addr and data in the next cycle.
- Pointer update (only when a grant occurs):
  - rd_ptr <= (index of the last read granted this cycle + 1) mod NUM_CLIENTS.
  - wr_ptr <= (write winner + 1) mod NUM_CLIENTS.
  - A pointer with no grant of its type holds its value.
- Owner tags:
  - On each clock edge, own_v[p] <= mem_r_en_p and own_id[p] <= the port p winner.
  - The write tag is updated the same way from mem_w_en and the write winner.
- Response routing, registered at memory latency (exactly 1 cycle after cl_gnt):
  - cl_rvalid[i] = 1 when (mem_r_valid_p & own_v[p] & own_id[p]==i) for either port; cl_rdata slice i = mem_data_out_p of that port.
  - cl_wack[i] = mem_w_valid & wr_own_v & wr_own_id==i.
  - At most one port targets a given client per cycle, because a client holds one outstanding request per grant.
- Unused cl_rdata slices are driven to 0.
- A single client with req=1 is granted every cycle (back-to-back).
- Two writes can never both be granted in one cycle; the loser waits at least one cycle.
- A held-off read is granted in the next cycle in which no write to that address is granted.

Test Plan:
- Reset: assert reset with cl_req=3'b111 -> cl_gnt=0, mem_r_en1=mem_r_en2=mem_w_en=0. Release reset -> client 0 granted first.
- Two reads: clients 0 and 1 read addresses 1 and 30 in the same cycle -> port1=addr 1 (client 0), port2=addr 30 (client 1). Next cycle both cl_rvalid are 1, with rdata = mem[1] and mem[30]=0x0000000F respectively.
- Three reads held for 3 cycles -> port-1 owners cycle 0, 2, 1 and port-2 owners 1, 0, 2 (round-robin, no starvation).
- Write conflict: clients 1 and 2 write 0xA5 and 0x5A to addr 2046 -> client 1 granted first, wack next cycle. Client 2 granted the following cycle. A final read of 2046 returns 0x5A.
- RAW hold-off: client 1 writes 0x1234 to addr 31 while client 0 reads addr 31 -> read withheld that cycle. It is granted the next cycle and returns 0x1234.
- Mid-flight reset: grant a read, then assert reset the next cycle -> no cl_rvalid, own_v cleared, pointers back to 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin 2-read/1-write memory port arbiter with owner-tagged response routing
module mem_port_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [NUM_CLIENTS-1:0]        cl_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]        cl_gnt,
  output logic [NUM_CLIENTS-1:0]        cl_rvalid,
  output logic [NUM_CLIENTS*DATA_W-1:0] cl_rdata,
  output logic [NUM_CLIENTS-1:0]        cl_wack,
  output logic [ADDR_W-1:0]             mem_r_adrs1,
  output logic [ADDR_W-1:0]             mem_r_adrs2,
  output logic                          mem_r_en1,
  output logic                          mem_r_en2,
  output logic [ADDR_W-1:0]             mem_w_adrs,
  output logic [DATA_W-1:0]             mem_data_in,
  output logic                          mem_w_en,
  input  logic                          mem_r_valid1,
  input  logic                          mem_r_valid2,
  input  logic                          mem_w_valid,
  input  logic [DATA_W-1:0]             mem_data_out1,
  input  logic [DATA_W-1:0]             mem_data_out2
);
  localparam int IW = $clog2(NUM_CLIENTS);
  typedef logic [IW-1:0] id_t;
  id_t rd_ptr, wr_ptr, r1_id, r2_id, w_id, own_id1, own_id2, wr_own_id;
  logic r1_v, r2_v, w_v, own_v1, own_v2, wr_own_v;
  logic [ADDR_W-1:0] w_addr;
  function automatic id_t rot(id_t p, int k);
    return id_t'((int'(p) + k) % NUM_CLIENTS);
  endfunction
  always_comb begin
    id_t j;
    j = '0;
    w_v = 1'b0;
    w_id = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      j = rot(wr_ptr, k);
      if (!reset && !w_v && cl_req[j] && cl_we[j]) begin
        w_v = 1'b1;
        w_id = j;
      end
    end
  end
  assign w_addr = cl_addr[w_id*ADDR_W +: ADDR_W];
  // reads that hit the address being written this cycle wait; there is no forwarding
  always_comb begin
    id_t j;
    j = '0;
    r1_v = 1'b0;
    r2_v = 1'b0;
    r1_id = '0;
    r2_id = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      j = rot(rd_ptr, k);
      if (!reset && cl_req[j] && !cl_we[j] && !(w_v && cl_addr[j*ADDR_W +: ADDR_W] == w_addr)) begin
        if (!r1_v) begin
          r1_v = 1'b1;
          r1_id = j;
        end else if (!r2_v) begin
          r2_v = 1'b1;
          r2_id = j;
        end
      end
    end
  end
  always_comb begin
    cl_gnt = '0;
    if (w_v) cl_gnt[w_id] = 1'b1;
    if (r1_v) cl_gnt[r1_id] = 1'b1;
    if (r2_v) cl_gnt[r2_id] = 1'b1;
  end
  assign mem_w_en    = w_v;
  assign mem_w_adrs  = w_addr;
  assign mem_data_in = cl_wdata[w_id*DATA_W +: DATA_W];
  assign mem_r_en1   = r1_v;
  assign mem_r_en2   = r2_v;
  assign mem_r_adrs1 = cl_addr[r1_id*ADDR_W +: ADDR_W];
  assign mem_r_adrs2 = cl_addr[r2_id*ADDR_W +: ADDR_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      own_v1 <= 1'b0;
      own_v2 <= 1'b0;
      wr_own_v <= 1'b0;
    end else begin
      if (r1_v) rd_ptr <= rot(r2_v ? r2_id : r1_id, 1);
      if (w_v) wr_ptr <= rot(w_id, 1);
      own_v1 <= r1_v;
      own_v2 <= r2_v;
      wr_own_v <= w_v;
      own_id1 <= r1_id;
      own_id2 <= r2_id;
      wr_own_id <= w_id;
    end
  end
  always_comb begin
    cl_rvalid = '0;
    cl_wack = '0;
    cl_rdata = '0;
    if (!reset && mem_r_valid1 && own_v1) begin
      cl_rvalid[own_id1] = 1'b1;
      cl_rdata[own_id1*DATA_W +: DATA_W] = mem_data_out1;
    end
    if (!reset && mem_r_valid2 && own_v2) begin
      cl_rvalid[own_id2] = 1'b1;
      cl_rdata[own_id2*DATA_W +: DATA_W] = mem_data_out2;
    end
    if (!reset && mem_w_valid && wr_own_v) cl_wack[wr_own_id] = 1'b1;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized model check
module tb_mem_port_arbiter;
  localparam int N = 3, AW = 11, DW = 32;
  logic clk = 1'b0, reset = 1'b1, mem_init = 1'b1, fv1 = 1'b0;
  logic [N-1:0] cl_req = '0, cl_we = '0, cl_gnt, cl_rvalid, cl_wack;
  logic [AW-1:0] ca [N];
  logic [DW-1:0] cw [N];
  logic [N*AW-1:0] cl_addr;
  logic [N*DW-1:0] cl_wdata, cl_rdata;
  logic [AW-1:0] mem_r_adrs1, mem_r_adrs2, mem_w_adrs;
  logic [DW-1:0] mem_data_in, d1, d2;
  logic mem_r_en1, mem_r_en2, mem_w_en, v1 = 0, v2 = 0, wv = 0, mem_r_valid1;
  logic [DW-1:0] mem [2048];
  int checks = 0, failures = 0;
  assign cl_addr = {ca[2], ca[1], ca[0]};
  assign cl_wdata = {cw[2], cw[1], cw[0]};
  assign mem_r_valid1 = v1 | fv1;
  always #5 clk = ~clk;
  mem_port_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr),
    .cl_wdata(cl_wdata), .cl_gnt(cl_gnt), .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata),
    .cl_wack(cl_wack), .mem_r_adrs1(mem_r_adrs1), .mem_r_adrs2(mem_r_adrs2),
    .mem_r_en1(mem_r_en1), .mem_r_en2(mem_r_en2), .mem_w_adrs(mem_w_adrs),
    .mem_data_in(mem_data_in), .mem_w_en(mem_w_en), .mem_r_valid1(mem_r_valid1),
    .mem_r_valid2(v2), .mem_w_valid(wv), .mem_data_out1(d1), .mem_data_out2(d2));
  // one-cycle-latency memory; contents start as mem[i] = i/2
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= DW'(i >> 1);
    end else begin
      v1 <= mem_r_en1;
      v2 <= mem_r_en2;
      wv <= mem_w_en;
      if (mem_r_en1) d1 <= mem[mem_r_adrs1];
      if (mem_r_en2) d2 <= mem[mem_r_adrs2];
      if (mem_w_en) mem[mem_w_adrs] <= mem_data_in;
    end
  end
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    cl_req = '0;
    cl_we = '0;
    tick();
    reset = 1'b0;
  endtask
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w, input int a0, input int a1, input int a2);
    cl_req = r;
    cl_we = w;
    ca[0] = AW'(a0);
    ca[1] = AW'(a1);
    ca[2] = AW'(a2);
  endtask
  typedef struct {
    logic [N-1:0] req, we;
    int a0, a1, a2;
    logic [N-1:0] gnt;
    logic en1, en2, wen;
  } vec_t;
  vec_t tv [6];
  initial begin
    int ww, r1, r2, rp, wp, j;
    int q[$];
    logic [N-1:0] eg, prv, pwk;
    logic [N*DW-1:0] prd;
    logic [DW-1:0] mm [2048];
    for (int i = 0; i < N; i++) begin
      ca[i] = '0;
      cw[i] = '0;
    end
    tv[0] = '{3'b111, 3'b000, 1, 30, 5, 3'b011, 1'b1, 1'b1, 1'b0};
    tv[1] = '{3'b110, 3'b010, 0, 31, 31, 3'b010, 1'b0, 1'b0, 1'b1};
    tv[2] = '{3'b111, 3'b111, 4, 5, 6, 3'b001, 1'b0, 1'b0, 1'b1};
    tv[3] = '{3'b100, 3'b000, 0, 0, 9, 3'b100, 1'b1, 1'b0, 1'b0};
    tv[4] = '{3'b000, 3'b000, 0, 0, 0, 3'b000, 1'b0, 1'b0, 1'b0};
    tv[5] = '{3'b111, 3'b001, 5, 5, 6, 3'b101, 1'b1, 1'b0, 1'b1};
    // reset with all clients requesting, then release: client 0 first, then rotation
    drive(3'b111, 3'b000, 100, 101, 102);
    @(negedge clk);
    chk("rst_gnt", 128'(cl_gnt), 128'(0));
    chk("rst_en", 128'({mem_r_en1, mem_r_en2, mem_w_en}), 128'(0));
    chk("rst_rvalid", 128'(cl_rvalid), 128'(0));
    tick();
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rel_gnt", 128'(cl_gnt), 128'(3'b011));
    chk("rel_rvalid", 128'(cl_rvalid), 128'(0));
    chk("rr1_p1", 128'(mem_r_adrs1), 128'(100));
    chk("rr1_p2", 128'(mem_r_adrs2), 128'(101));
    tick();
    @(negedge clk);
    chk("rr2_p1", 128'(mem_r_adrs1), 128'(102));
    chk("rr2_p2", 128'(mem_r_adrs2), 128'(100));
    chk("rr2_rvalid", 128'(cl_rvalid), 128'(3'b011));
    tick();
    @(negedge clk);
    chk("rr3_p1", 128'(mem_r_adrs1), 128'(101));
    chk("rr3_p2", 128'(mem_r_adrs2), 128'(102));
    // two reads in one cycle
    do_reset();
    drive(3'b011, 3'b000, 1, 30, 0);
    @(negedge clk);
    chk("two_p1", 128'(mem_r_adrs1), 128'(1));
    chk("two_p2", 128'(mem_r_adrs2), 128'(30));
    tick();
    cl_req = '0;
    @(negedge clk);
    chk("two_rvalid", 128'(cl_rvalid), 128'(3'b011));
    chk("two_rdata", 128'(cl_rdata), 128'({32'h0, 32'hF, 32'h0}));
    // write conflict on 2046
    do_reset();
    cw[1] = 32'hA5;
    cw[2] = 32'h5A;
    drive(3'b110, 3'b110, 0, 2046, 2046);
    @(negedge clk);
    chk("wc1_gnt", 128'(cl_gnt), 128'(3'b010));
    chk("wc1_data", 128'({mem_w_adrs, mem_data_in}), 128'({11'd2046, 32'hA5}));
    tick();
    cl_req = 3'b100;
    @(negedge clk);
    chk("wc1_wack", 128'(cl_wack), 128'(3'b010));
    chk("wc2_gnt", 128'(cl_gnt), 128'(3'b100));
    chk("wc2_data", 128'(mem_data_in), 128'(32'h5A));
    tick();
    drive(3'b001, 3'b000, 2046, 0, 0);
    @(negedge clk);
    chk("wc2_wack", 128'(cl_wack), 128'(3'b100));
    chk("wc_rd_gnt", 128'(cl_gnt), 128'(3'b001));
    tick();
    cl_req = '0;
    @(negedge clk);
    chk("wc_rd_rvalid", 128'(cl_rvalid), 128'(3'b001));
    chk("wc_rd_rdata", 128'(cl_rdata), 128'({64'h0, 32'h5A}));
    // read-after-write hold-off
    do_reset();
    cw[1] = 32'h1234;
    drive(3'b011, 3'b010, 31, 31, 0);
    @(negedge clk);
    chk("raw_gnt", 128'(cl_gnt), 128'(3'b010));
    chk("raw_en1", 128'(mem_r_en1), 128'(0));
    tick();
    cl_req = 3'b001;
    @(negedge clk);
    chk("raw_gnt2", 128'(cl_gnt), 128'(3'b001));
    chk("raw_adrs", 128'(mem_r_adrs1), 128'(31));
    chk("raw_wack", 128'(cl_wack), 128'(3'b010));
    tick();
    cl_req = '0;
    @(negedge clk);
    chk("raw_rvalid", 128'(cl_rvalid), 128'(3'b001));
    chk("raw_rdata", 128'(cl_rdata), 128'({64'h0, 32'h1234}));
    // reset while a read is in flight; a stray strobe afterwards must be ignored
    do_reset();
    drive(3'b001, 3'b000, 5, 0, 0);
    @(negedge clk);
    chk("mf_gnt", 128'(cl_gnt), 128'(3'b001));
    tick();
    reset = 1'b1;
    cl_req = '0;
    @(negedge clk);
    chk("mf_rvalid_rst", 128'(cl_rvalid), 128'(0));
    chk("mf_rdata_rst", 128'(cl_rdata), 128'(0));
    tick();
    reset = 1'b0;
    fv1 = 1'b1;
    drive(3'b111, 3'b000, 100, 101, 102);
    @(negedge clk);
    chk("mf_rvalid_after", 128'(cl_rvalid), 128'(0));
    chk("mf_ptr_p1", 128'(mem_r_adrs1), 128'(100));
    chk("mf_gnt_after", 128'(cl_gnt), 128'(3'b011));
    tick();
    fv1 = 1'b0;
    // single-cycle vectors from reset state
    for (int t = 0; t < 6; t++) begin
      do_reset();
      drive(tv[t].req, tv[t].we, tv[t].a0, tv[t].a1, tv[t].a2);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", t), 128'(cl_gnt), 128'(tv[t].gnt));
      chk($sformatf("vec%0d_en1", t), 128'(mem_r_en1), 128'(tv[t].en1));
      chk($sformatf("vec%0d_en2", t), 128'(mem_r_en2), 128'(tv[t].en2));
      chk($sformatf("vec%0d_wen", t), 128'(mem_w_en), 128'(tv[t].wen));
    end
    // randomized traffic against a rule-level reference model
    mem_init = 1'b1;
    do_reset();
    mem_init = 1'b0;
    for (int i = 0; i < 2048; i++) mm[i] = DW'(i >> 1);
    rp = 0;
    wp = 0;
    prv = '0;
    pwk = '0;
    prd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 0) begin
        for (int k = 0; k < N; k++) begin
          cl_req[k] = $urandom_range(0, 9) < 7;
          cl_we[k] = $urandom_range(0, 9) < 4;
          ca[k] = AW'($urandom_range(0, 3));
          cw[k] = $urandom;
        end
      end
      @(negedge clk);
      ww = -1;
      for (int k = 0; k < N; k++) begin
        j = (wp + k) % N;
        if (ww < 0 && cl_req[j] && cl_we[j]) ww = j;
      end
      q.delete();
      for (int k = 0; k < N; k++) begin
        j = (rp + k) % N;
        if (cl_req[j] && !cl_we[j] && !(ww >= 0 && ca[j] == ca[ww])) q.push_back(j);
      end
      r1 = q.size() > 0 ? q[0] : -1;
      r2 = q.size() > 1 ? q[1] : -1;
      eg = '0;
      if (ww >= 0) eg[ww] = 1'b1;
      if (r1 >= 0) eg[r1] = 1'b1;
      if (r2 >= 0) eg[r2] = 1'b1;
      chk("rnd_gnt", 128'(cl_gnt), 128'(eg));
      chk("rnd_en", 128'({mem_r_en1, mem_r_en2, mem_w_en}), 128'({r1 >= 0, r2 >= 0, ww >= 0}));
      if (ww >= 0) chk("rnd_w", 128'({mem_w_adrs, mem_data_in}), 128'({ca[ww], cw[ww]}));
      if (r1 >= 0) chk("rnd_a1", 128'(mem_r_adrs1), 128'(ca[r1]));
      if (r2 >= 0) chk("rnd_a2", 128'(mem_r_adrs2), 128'(ca[r2]));
      chk("rnd_rvalid", 128'(cl_rvalid), 128'(prv));
      chk("rnd_wack", 128'(cl_wack), 128'(pwk));
      chk("rnd_rdata", 128'(cl_rdata), 128'(prd));
      prv = '0;
      pwk = '0;
      prd = '0;
      if (r1 >= 0) begin
        prv[r1] = 1'b1;
        prd[r1*DW +: DW] = mm[ca[r1]];
      end
      if (r2 >= 0) begin
        prv[r2] = 1'b1;
        prd[r2*DW +: DW] = mm[ca[r2]];
      end
      if (ww >= 0) begin
        pwk[ww] = 1'b1;
        mm[ca[ww]] = cw[ww];
        wp = (ww + 1) % N;
      end
      if (r1 >= 0) rp = ((r2 >= 0 ? r2 : r1) + 1) % N;
      tick();
      for (int k = 0; k < N; k++) begin
        if (!cl_req[k] || eg[k]) begin
          cl_req[k] = $urandom_range(0, 9) < 7;
          cl_we[k] = $urandom_range(0, 9) < 4;
          ca[k] = $urandom_range(0, 7) == 0 ? AW'($urandom) : AW'($urandom_range(0, 3));
          cw[k] = $urandom;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
